// File: rtl/pulse_stretch_pkg.sv
// Shared types and constants for the pulse stretcher arbiter slice.
package pulse_stretch_pkg;

    localparam int unsigned CFG_W_DEF     = 16;
    localparam int unsigned GUARD_CNT_W   = 8;
    localparam int unsigned TIMEOUT_CNT_W = 17;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        WAIT_HI,
        WAIT_LO,
        GUARD
    } state_e;

endpackage

// File: rtl/pulse_stretch_arbiter_if.sv
// Requester/stretcher-side bundle of the pulse stretcher arbiter.
// PULSE_STRETCH_ARB_TIMEOUT_EN adds the timeout_err signal.
interface pulse_stretch_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CFG_W = 16
) ();
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_i;
    logic [N_REQ*CFG_W-1:0] cfg_i;
    logic [N_REQ-1:0]       ack_o;
    logic                   pulse_reg;
    logic [CFG_W-1:0]       config_reg;
    logic                   pulse_out_i;
    logic [IDX_W-1:0]       grant_id;
    logic                   busy;
`ifdef PULSE_STRETCH_ARB_TIMEOUT_EN
    logic                   timeout_err;
`endif

    modport master (
        output req_i, cfg_i, pulse_out_i,
        input  ack_o, pulse_reg, config_reg, grant_id, busy
`ifdef PULSE_STRETCH_ARB_TIMEOUT_EN
        , input timeout_err
`endif
    );

    modport slave (
        input  req_i, cfg_i, pulse_out_i,
        output ack_o, pulse_reg, config_reg, grant_id, busy
`ifdef PULSE_STRETCH_ARB_TIMEOUT_EN
        , output timeout_err
`endif
    );

endinterface

// File: rtl/pulse_stretch_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request searching upward from ptr+1.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     valid_o
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    int unsigned      j;
    logic [IDX_W-1:0] k;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        k       = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            j = (32'(ptr_i) + i) % N_REQ;
            k = IDX_W'(j);
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                idx_o    = k;
                gnt_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_stretch_arbiter.sv
// Round-robin sharing of one pulse stretcher among N_REQ trigger sources.
// PULSE_STRETCH_ARB_TIMEOUT_EN enables the WAIT_HI/WAIT_LO watchdog.
module pulse_stretch_arbiter
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned CFG_W     = CFG_W_DEF,
    parameter int unsigned GUARD_CYC = 2
`ifdef PULSE_STRETCH_ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 65600
`endif
) (
    input logic                    clk,
    input logic                    rst,
    pulse_stretch_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_e                 state_q;
    logic [N_REQ-1:0]       ack_q;
    logic [N_REQ-1:0]       gnt_q;
    logic                   pulse_q;
    logic [CFG_W-1:0]       cfg_q;
    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       ptr_q;
    logic                   busy_q;
    logic [GUARD_CNT_W-1:0] guard_q;

    logic [N_REQ-1:0]       arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_valid;
    logic [CFG_W-1:0]       cfg_win;

`ifdef PULSE_STRETCH_ARB_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] to_cnt_q;
    logic                     to_err_q;
    assign bus.timeout_err = to_err_q;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req_i   (bus.req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Width field of the current arbitration winner.
    always_comb begin
        cfg_win = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) cfg_win = bus.cfg_i[i*CFG_W +: CFG_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ack_q   <= '0;
            gnt_q   <= '0;
            pulse_q <= 1'b0;
            cfg_q   <= '0;
            grant_q <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            busy_q  <= 1'b0;
            guard_q <= '0;
`ifdef PULSE_STRETCH_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
`endif
        end else begin
            ack_q   <= '0;
            pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                        grant_q <= arb_idx;
                        ptr_q   <= arb_idx;
                        gnt_q   <= arb_gnt;
                        cfg_q   <= cfg_win;
                        // Zero-width grants are acked during ARM and never fire.
                        if (cfg_win == '0) ack_q <= arb_gnt;
                    end
                end
                ARM: begin
                    if (cfg_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= FIRE;
                        pulse_q <= 1'b1;
                        ack_q   <= gnt_q;
                    end
                end
                FIRE: begin
                    state_q <= WAIT_HI;
`ifdef PULSE_STRETCH_ARB_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                end
                WAIT_HI: begin
                    if (bus.pulse_out_i) state_q <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!bus.pulse_out_i) begin
                        state_q <= GUARD;
                        guard_q <= '0;
                    end
                end
                GUARD: begin
                    if ((32'(guard_q) + 32'd1) >= GUARD_CYC) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        guard_q <= guard_q + GUARD_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
`ifdef PULSE_STRETCH_ARB_TIMEOUT_EN
            // Watchdog overrides the WAIT transitions when the stretcher never answers.
            if (state_q == WAIT_HI || state_q == WAIT_LO) begin
                if (to_cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYC - 1)) begin
                    to_err_q <= 1'b1;
                    state_q  <= GUARD;
                    guard_q  <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + TIMEOUT_CNT_W'(1);
                end
            end
`endif
        end
    end

    assign bus.ack_o      = ack_q;
    assign bus.pulse_reg  = pulse_q;
    assign bus.config_reg = cfg_q;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_pulse_stretch_arbiter.sv
// Directed bench for pulse_stretch_arbiter with a behavioural stretcher model.
module tb_pulse_stretch_arbiter;

    logic clk;
    logic rst;
    logic stuck;
    int   n_checks;
    int   n_errors;
    int   pulse_cnt;
    int   onehot_err;
    int   ack_log[$];
    logic [15:0] pcnt;

    pulse_stretch_arbiter_if #(.N_REQ(4), .CFG_W(16)) bus ();

    pulse_stretch_arbiter #(
        .N_REQ     (4),
        .CFG_W     (16),
        .GUARD_CYC (2)
`ifdef PULSE_STRETCH_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC (20)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stretcher: pulse_out rises one cycle after pulse_reg and stays high config_reg cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.pulse_out_i <= 1'b0;
            pcnt            <= '0;
        end else if (bus.pulse_reg && !stuck) begin
            bus.pulse_out_i <= 1'b1;
            pcnt            <= bus.config_reg - 16'd1;
        end else if (pcnt != 0) begin
            pcnt <= pcnt - 16'd1;
        end else begin
            bus.pulse_out_i <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            if (bus.pulse_reg) pulse_cnt++;
            if ($countones(bus.ack_o) > 1) onehot_err++;
            for (int i = 0; i < 4; i++) if (bus.ack_o[i]) ack_log.push_back(i);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int idx, input logic [15:0] v);
        bus.cfg_i[idx*16 +: 16] = v;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ack_log.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        int rr_exp[5];
        int got;
        int p0;
        rr_exp     = '{0, 1, 2, 3, 0};
        n_checks   = 0;
        n_errors   = 0;
        pulse_cnt  = 0;
        onehot_err = 0;
        stuck      = 1'b0;
        rst        = 1'b0;
        bus.req_i  = '0;
        bus.cfg_i  = '0;
        tick();
        tick();
        check("rst_ack",    32'(bus.ack_o),      32'd0);
        check("rst_pulse",  32'(bus.pulse_reg),  32'd0);
        check("rst_config", 32'(bus.config_reg), 32'd0);
        check("rst_grant",  32'(bus.grant_id),   32'd0);
        check("rst_busy",   32'(bus.busy),       32'd0);
        rst = 1'b1;

        // Single request, width 5.
        tick();
        bus.req_i = 4'b0001;
        set_cfg(0, 16'd5);
        tick();
        check("t1_arm_busy",   32'(bus.busy),       32'd1);
        check("t1_arm_config", 32'(bus.config_reg), 32'd5);
        check("t1_arm_ack",    32'(bus.ack_o),      32'd0);
        check("t1_arm_pulse",  32'(bus.pulse_reg),  32'd0);
        tick();
        check("t1_fire_pulse", 32'(bus.pulse_reg),  32'd1);
        check("t1_fire_ack",   32'(bus.ack_o),      32'd1);
        bus.req_i = 4'b0000;
        n = 0;
        while (bus.busy && n < 50) begin
            tick();
            n++;
        end
        check("t1_busy_fall", 32'(n), 32'd9);
        check("t1_pulse_cnt", 32'(pulse_cnt), 32'd1);

        // Round-robin with all four requests held.
        do_reset();
        for (int i = 0; i < 4; i++) set_cfg(i, 16'd3);
        bus.req_i = 4'b1111;
        n = 0;
        while (ack_log.size() < 5 && n < 300) begin
            tick();
            n++;
        end
        bus.req_i = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            got = (i < ack_log.size()) ? ack_log[i] : 99;
            check($sformatf("rr_order_%0d", i), 32'(got), 32'(rr_exp[i]));
        end
        wait_idle("rr_idle");

        // Zero width: ack in ARM, no pulse.
        do_reset();
        p0 = pulse_cnt;
        bus.req_i = 4'b0100;
        set_cfg(2, 16'd0);
        tick();
        check("zw_ack",   32'(bus.ack_o),     32'h4);
        check("zw_pulse", 32'(bus.pulse_reg), 32'd0);
        check("zw_grant", 32'(bus.grant_id),  32'd2);
        check("zw_busy",  32'(bus.busy),      32'd1);
        bus.req_i = 4'b0000;
        tick();
        check("zw_ack_clr", 32'(bus.ack_o), 32'd0);
        check("zw_idle",    32'(bus.busy),  32'd0);
        tick();
        check("zw_no_pulse", 32'(pulse_cnt - p0), 32'd0);

        // Request arriving while busy waits for the guard gap.
        do_reset();
        set_cfg(0, 16'd10);
        set_cfg(1, 16'd7);
        bus.req_i = 4'b0001;
        tick();
        bus.req_i = 4'b0011;
        tick();
        check("q_ack0", 32'(bus.ack_o), 32'h1);
        bus.req_i = 4'b0010;
        set_cfg(1, 16'd9);
        n = 0;
        while (!bus.ack_o[1] && n < 60) begin
            tick();
            n++;
        end
        check("q_ack1_lat", 32'(n),              32'd16);
        check("q_grant1",   32'(bus.grant_id),   32'd1);
        check("q_cfg1",     32'(bus.config_reg), 32'd9);
        bus.req_i = 4'b0000;
        set_cfg(1, 16'd2);
        tick();
        check("q_cfg_hold", 32'(bus.config_reg), 32'd9);
        wait_idle("q_idle");

        // Asynchronous reset while in WAIT_LO.
        do_reset();
        set_cfg(0, 16'd6);
        set_cfg(1, 16'd6);
        bus.req_i = 4'b0001;
        tick();
        tick();
        bus.req_i = 4'b0000;
        tick();
        tick();
        tick();
        check("ar_pre_busy",   32'(bus.busy),        32'd1);
        check("ar_pre_pout",   32'(bus.pulse_out_i), 32'd1);
        check("ar_pre_config", 32'(bus.config_reg),  32'd6);
        rst = 1'b0;
        #1;
        check("ar_busy",   32'(bus.busy),        32'd0);
        check("ar_config", 32'(bus.config_reg),  32'd0);
        check("ar_ack",    32'(bus.ack_o),       32'd0);
        check("ar_pulse",  32'(bus.pulse_reg),   32'd0);
        check("ar_pout",   32'(bus.pulse_out_i), 32'd0);
        tick();
        rst = 1'b1;
        bus.req_i = 4'b0011;
        tick();
        check("ar_first_grant", 32'(bus.grant_id), 32'd0);
        bus.req_i = 4'b0000;
        wait_idle("ar_idle");

`ifdef PULSE_STRETCH_ARB_TIMEOUT_EN
        // Stuck stretcher trips the watchdog after 20 wait cycles.
        do_reset();
        stuck = 1'b1;
        set_cfg(0, 16'd4);
        bus.req_i = 4'b0001;
        tick();
        tick();
        bus.req_i = 4'b0000;
        repeat (20) tick();
        check("to_err_before", 32'(bus.timeout_err), 32'd0);
        tick();
        check("to_err_set", 32'(bus.timeout_err), 32'd1);
        stuck = 1'b0;
        wait_idle("to_idle");
        bus.req_i = 4'b0010;
        set_cfg(1, 16'd2);
        tick();
        tick();
        check("to_next_ack", 32'(bus.ack_o),       32'h2);
        check("to_sticky",   32'(bus.timeout_err), 32'd1);
        bus.req_i = 4'b0000;
        wait_idle("to_next_idle");
`endif

        check("ack_onehot", 32'(onehot_err), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
